// File: rtl/rv32i_pipe_pkg.sv
// Shared definitions for the RV32I elastic pipeline stages.
// State encoding and control-bit positions used by every stage register.
package rv32i_pipe_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_BUSY  = 2'd1;
  localparam state_t ST_FULL  = 2'd2;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_BRANCH   = 4;

  function automatic logic [1:0] occ_of(
    input logic mv,
    input logic sv
  );
    return {1'b0, mv} + {1'b0, sv};
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer.
// Registered in_ready; flush turns all held entries into bubbles.
module pipe_stage_skid
  import rv32i_pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 5
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  state_t state, state_nx;

  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic main_valid, skid_valid;
  logic in_fire, out_fire;
  logic load_main_in, load_main_skid, load_skid;

  assign main_valid = (state == ST_BUSY) || (state == ST_FULL);
  assign skid_valid = (state == ST_FULL);

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};
  assign occupancy = occ_of(main_valid, skid_valid);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_nx       = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nx = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state_nx     = ST_BUSY;
            load_main_in = 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_nx  = ST_FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_nx = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_nx       = ST_BUSY;
            load_main_skid = 1'b1;
          end
        end
        default: state_nx = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state <= ST_EMPTY;
    else         state <= state_nx;
  end

  // Skid entry always drains into main first, keeping FIFO order.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid.
// Queue-based reference model plus directed and random traffic.
module tb_pipe_stage_skid;

  localparam int DW = 96;
  localparam int CW = 5;

  logic          CLK = 1'b0;
  logic          nRESET = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW+CW-1:0] q[$];

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .CLK(CLK),
    .nRESET(nRESET),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_ctrl(in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a FIFO of at most two entries; flush empties it.
  always @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      q.delete();
    end else begin : upd
      bit inf, outf;
      inf  = in_valid && (q.size() < 2);
      outf = out_ready && (q.size() != 0);
      if (flush) begin
        q.delete();
      end else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back({in_data, in_ctrl});
      end
    end
  end

  task automatic model_check();
    logic [DW+CW-1:0] h;
    chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
    chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
    chk("occupancy", 128'(occupancy), 128'(q.size()));
    if (q.size() != 0) begin
      h = q[0];
      chk("out_data", 128'(out_data), 128'(h[DW+CW-1:CW]));
      chk("out_ctrl", 128'(out_ctrl), 128'(h[CW-1:0]));
    end else begin
      chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    model_check();
  endtask

  task automatic drive(
    input logic          iv,
    input logic [DW-1:0] d,
    input logic [CW-1:0] c,
    input logic          ordy,
    input logic          fl
  );
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_occ", 128'(occupancy), 128'(0));
    #11 nRESET = 1'b1;
    tick();

    // Fill to two entries, then reset asynchronously between edges.
    drive(1, 96'h11, 5'h3, 0, 0);
    tick();
    drive(1, 96'h22, 5'h4, 0, 0);
    tick();
    chk("pre_rst_occ", 128'(occupancy), 128'(2));
    drive(0, '0, '0, 0, 0);
    #2 nRESET = 1'b0;
    #1;
    chk("async_out_valid", 128'(out_valid), 128'(0));
    chk("async_out_ctrl", 128'(out_ctrl), 128'(0));
    chk("async_out_data", 128'(out_data), 128'(0));
    chk("async_occ", 128'(occupancy), 128'(0));
    chk("async_in_ready", 128'(in_ready), 128'(1));
    #1 nRESET = 1'b1;
    tick();

    // Streaming 1..8 with one-cycle latency.
    for (int i = 1; i <= 8; i++) begin
      drive(1, DW'(i), CW'(i), 1, 0);
      tick();
      chk("stream_data", 128'(out_data), 128'(i));
      chk("stream_occ", 128'(occupancy), 128'(1));
    end
    drive(0, '0, '0, 1, 0);
    tick();

    // Stall with A,B then release.
    drive(1, 96'hA, 5'h1, 0, 0);
    tick();
    drive(1, 96'hB, 5'h2, 0, 0);
    tick();
    chk("stall_occ", 128'(occupancy), 128'(2));
    chk("stall_in_ready", 128'(in_ready), 128'(0));
    chk("stall_data", 128'(out_data), 128'(96'hA));
    drive(0, '0, '0, 0, 0);
    tick();
    chk("stall_hold", 128'(out_data), 128'(96'hA));
    drive(0, '0, '0, 1, 0);
    tick();
    chk("release_b", 128'(out_data), 128'(96'hB));
    tick();
    chk("release_empty", 128'(occupancy), 128'(0));

    // Flush a full stage while C is offered.
    drive(1, 96'h1A, 5'b01111, 0, 0);
    tick();
    drive(1, 96'h1B, 5'b01111, 0, 0);
    tick();
    drive(1, 96'hC, 5'b01111, 0, 1);
    tick();
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_ctrl", 128'(out_ctrl), 128'(0));
    chk("flush_occ", 128'(occupancy), 128'(0));
    drive(0, '0, '0, 1, 0);
    repeat (2) tick();
    chk("flush_no_c", 128'(out_valid), 128'(0));

    // FULL with out_fire and in_valid in the same cycle.
    drive(1, 96'hD, 5'h5, 0, 0);
    tick();
    drive(1, 96'hE, 5'h6, 0, 0);
    tick();
    drive(1, 96'hF, 5'h7, 1, 0);
    tick();
    chk("simul_occ", 128'(occupancy), 128'(1));
    chk("simul_main", 128'(out_data), 128'(96'hE));
    drive(0, '0, '0, 1, 0);
    tick();
    chk("simul_drop_f", 128'(occupancy), 128'(0));

    // Random traffic against the reference.
    for (int n = 0; n < 10000; n++) begin
      if (!(in_valid && q.size() >= 2)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = {$urandom, $urandom, $urandom};
        in_ctrl  = CW'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
